// File: rtl/kernel_window_sequencer.sv
// rtl/kernel_window_sequencer.sv - walks a SIZE x SIZE kernel window and drives the accumulator handshake
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         window request handshake; req_x/req_y origin
//   kern_addr/kern_data         kernel coefficient memory (1-cycle read latency)
//   pix_x/pix_y/pix_data        image pixel memory (1-cycle read latency)
//   acc_clear/acc_start         pulses to the accumulator
//   acc_kernel_v/acc_pixel_v    accumulator operands (holding registers)
//   acc_ready/acc_clear_flag    accumulator status; acc_sum is its result byte
//   result_valid/result_ready   result handshake; result carries acc_sum
//
// Build option: KWS_SKIP_ZERO_EN skips issuing taps whose coefficient is zero.
module kernel_window_sequencer #(
  parameter int SIZE = 3,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_x,
  input  logic [3:0]    req_y,
  output logic [AW-1:0] kern_addr,
  input  logic [7:0]    kern_data,
  output logic [3:0]    pix_x,
  output logic [3:0]    pix_y,
  input  logic [7:0]    pix_data,
  output logic          acc_clear,
  output logic          acc_start,
  output logic [7:0]    acc_kernel_v,
  output logic [7:0]    acc_pixel_v,
  input  logic          acc_ready,
  input  logic          acc_clear_flag,
  input  logic [7:0]    acc_sum,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [7:0]    result
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, WAIT_CLR, FETCH, LOAD, ISSUE, HOLD, WAIT_SUM, OUT
  } state_t;

  localparam logic [2:0] LAST = 3'(SIZE - 1);

  state_t     state, state_next;
  logic [3:0] org_x, org_y;
  logic [2:0] tx, ty;
  logic [7:0] kern_hold, pix_hold, result_q;
  logic       req_ready_q;
  logic       last_tap;
  logic       advance;

  assign last_tap = (tx == LAST) && (ty == LAST);

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    case (state)
      IDLE:     if (req_valid && req_ready_q) state_next = CLEAR;
      CLEAR:    if (acc_ready) state_next = WAIT_CLR;
      WAIT_CLR: if (acc_clear_flag) state_next = FETCH;
      FETCH:    state_next = LOAD;
      LOAD: begin
`ifdef KWS_SKIP_ZERO_EN
        if (kern_data == 8'd0) begin
          if (last_tap) begin
            state_next = WAIT_SUM;
          end else begin
            state_next = FETCH;
            advance    = 1'b1;
          end
        end else begin
          state_next = ISSUE;
        end
`else
        state_next = ISSUE;
`endif
      end
      ISSUE:    if (acc_ready) state_next = HOLD;
      HOLD: begin
        if (last_tap) begin
          state_next = WAIT_SUM;
        end else begin
          state_next = FETCH;
          advance    = 1'b1;
        end
      end
      WAIT_SUM: if (acc_ready) state_next = OUT;
      OUT:      if (result_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready_q <= 1'b0;
      org_x       <= 4'd0;
      org_y       <= 4'd0;
      tx          <= 3'd0;
      ty          <= 3'd0;
      kern_hold   <= 8'd0;
      pix_hold    <= 8'd0;
      result_q    <= 8'd0;
    end else begin
      state <= state_next;
      // Registered so req_ready stays low through reset and the cycle after it.
      req_ready_q <= (state_next == IDLE);
      if (state == IDLE && state_next == CLEAR) begin
        org_x <= req_x;
        org_y <= req_y;
        tx    <= 3'd0;
        ty    <= 3'd0;
      end
      // Operands only change for a tap that will actually be issued.
      if (state == LOAD && state_next == ISSUE) begin
        kern_hold <= kern_data;
        pix_hold  <= pix_data;
      end
      if (advance) begin
        if (tx == LAST) begin
          tx <= 3'd0;
          ty <= ty + 3'd1;
        end else begin
          tx <= tx + 3'd1;
        end
      end
      if (state == WAIT_SUM && acc_ready) result_q <= acc_sum;
    end
  end

  assign req_ready    = req_ready_q;
  assign kern_addr    = AW'(ty) * AW'(SIZE) + AW'(tx);
  assign pix_x        = org_x + {1'b0, tx};
  assign pix_y        = org_y + {1'b0, ty};
  // Gated by rst so an abandoned transaction never leaks a pulse.
  assign acc_clear    = (state == CLEAR) && acc_ready && !rst;
  assign acc_start    = (state == ISSUE) && acc_ready && !rst;
  assign acc_kernel_v = kern_hold;
  assign acc_pixel_v  = pix_hold;
  assign result_valid = (state == OUT);
  assign result       = result_q;

endmodule

// File: tb/tb_kernel_window_sequencer.sv
// tb/tb_kernel_window_sequencer.sv - scoreboard bench for kernel_window_sequencer
module tb_kernel_window_sequencer;
  localparam int SIZE = 3;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_x = 4'd0, req_y = 4'd0;
  logic [AW-1:0] kern_addr;
  logic [7:0]    kern_data = 8'd0;
  logic [3:0]    pix_x, pix_y;
  logic [7:0]    pix_data = 8'd0;
  logic          acc_clear, acc_start;
  logic [7:0]    acc_kernel_v, acc_pixel_v;
  logic          acc_ready, acc_clear_flag;
  logic [7:0]    acc_sum;
  logic          result_valid;
  logic          result_ready = 1'b1;
  logic [7:0]    result;

  kernel_window_sequencer #(.SIZE(SIZE), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .kern_addr(kern_addr), .kern_data(kern_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .acc_clear(acc_clear), .acc_start(acc_start),
    .acc_kernel_v(acc_kernel_v), .acc_pixel_v(acc_pixel_v),
    .acc_ready(acc_ready), .acc_clear_flag(acc_clear_flag), .acc_sum(acc_sum),
    .result_valid(result_valid), .result_ready(result_ready), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] kmem [0:63];
  logic [7:0] pmem [0:255];
  always @(posedge clk) begin
    kern_data <= kmem[kern_addr];
    pix_data  <= pmem[{pix_y, pix_x}];
  end

  // Accumulator model: multiply in the cycle after start, add the next, ready after that.
  logic [15:0] acc = 16'd0;
  int          busy = 0;
  logic        flag = 1'b0;
  assign acc_ready      = (busy == 0);
  assign acc_sum        = acc[15:8];
  assign acc_clear_flag = flag;
  always @(posedge clk) begin
    if (acc_clear) begin
      acc  <= 16'd0;
      flag <= 1'b1;
    end
    if (acc_start) begin
      busy <= 2;
      flag <= 1'b0;
    end else if (busy == 2) begin
      acc  <= acc + acc_kernel_v * acc_pixel_v;
      busy <= 1;
    end else if (busy == 1) begin
      busy <= 0;
    end
  end

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];
  int hs_cnt = 0;
  int n_start = 0;
  int n_clr = 0;
  int tr_x [$];
  int tr_y [$];
  int tr_a [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each result handshake.
  always @(negedge clk) begin
    if (!rst && result_valid && result_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", {56'd0, result}, 64'hdead);
      end else begin
        check("result", {56'd0, result}, {56'd0, exp_q.pop_front()});
      end
    end
    if (acc_start) begin
      n_start++;
      tr_x.push_back(int'(pix_x));
      tr_y.push_back(int'(pix_y));
      tr_a.push_back(int'(kern_addr));
    end
    if (acc_clear) n_clr++;
    if (acc_start && acc_clear) check("pulse_overlap", 64'd1, 64'd0);
  end

  task automatic fill(input logic [7:0] k, input logic [7:0] p);
    for (int i = 0; i < 64; i++) kmem[i] = k;
    for (int i = 0; i < 256; i++) pmem[i] = p;
  endtask

  task automatic accept_request(input logic [3:0] x, input logic [3:0] y, output int t0);
    int guard;
    req_x = x;
    req_y = y;
    req_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 50);
    if (!req_ready) check("accept_timeout", 64'd0, 64'd1);
    t0 = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_x = ~x;
    req_y = ~y;
  endtask

  task automatic run_window(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp_r,
                            input int lat, input int nst, input int bp);
    int t0, guard, hs0;
    logic [7:0] r0;
    n_start = 0;
    n_clr = 0;
    tr_x.delete();
    tr_y.delete();
    tr_a.delete();
    exp_q.push_back(exp_r);
    hs0 = hs_cnt;
    result_ready = (bp == 0);
    accept_request(x, y, t0);
    guard = 0;
    while (!result_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("latency", 64'(cyc - t0), 64'(lat));
    if (bp > 0) begin
      r0 = result;
      req_valid = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        check("bp_result_stable", {56'd0, result}, {56'd0, r0});
        check("bp_valid_held", {63'd0, result_valid}, 64'd1);
        check("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
      end
      @(posedge clk);
      #1;
      result_ready = 1'b1;
      @(negedge clk);
      check("no_bypass_req_ready", {63'd0, req_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    check("handshakes", 64'(hs_cnt - hs0), 64'd1);
    check("start_pulses", 64'(n_start), 64'(nst));
    check("clear_pulses", 64'(n_clr), 64'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int t0;
    int exp_x [3];
    int exp_y [3];
    exp_x = '{14, 15, 0};
    exp_y = '{15, 0, 1};
    fill(8'h01, 8'h80);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {22'd0, req_ready, kern_addr, pix_x, pix_y, acc_clear, acc_start,
           acc_kernel_v, acc_pixel_v, result_valid, result}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Unit kernel, mid-grey pixels
    run_window(4'd0, 4'd0, 8'h04, 41, 9, 0);

    // All 0xFF: 16-bit sum wraps to 0xEE09
    fill(8'hFF, 8'hFF);
    run_window(4'd3, 4'd5, 8'hEE, 41, 9, 0);

    // Coordinate wrap at origin (14,15)
    fill(8'h01, 8'h80);
    run_window(4'd14, 4'd15, 8'h04, 41, 9, 0);
    check("trace_len", 64'(tr_x.size()), 64'd9);
    for (int k = 0; k < 9 && k < tr_x.size(); k++) begin
      check("pix_x_seq", 64'(tr_x[k]), 64'(exp_x[k % 3]));
      check("pix_y_seq", 64'(tr_y[k]), 64'(exp_y[k / 3]));
      check("kern_addr_seq", 64'(tr_a[k]), 64'(k));
    end

    // Output backpressure; a pending request waits for the handshake
    fill(8'hFF, 8'hFF);
    run_window(4'd0, 4'd0, 8'hEE, 41, 9, 10);
    fill(8'h01, 8'h80);
    run_window(4'd0, 4'd0, 8'h04, 41, 9, 0);

    // Reset during tap 4 ISSUE
    n_start = 0;
    t0 = 0;
    accept_request(4'd0, 4'd0, t0);
    while (cyc != t0 + 21) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_start_suppressed", {63'd0, acc_start}, 64'd0);
    check("rst_taps_before", 64'(n_start), 64'd4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs",
          {22'd0, req_ready, kern_addr, pix_x, pix_y, acc_clear, acc_start,
           acc_kernel_v, acc_pixel_v, result_valid, result}, 64'd0);
    @(posedge clk);
    #1;
    run_window(4'd0, 4'd0, 8'h04, 41, 9, 0);

    // Center-only kernel
    fill(8'h00, 8'h33);
    kmem[4] = 8'h40;
    pmem[{4'd1, 4'd1}] = 8'h10;
`ifdef KWS_SKIP_ZERO_EN
    run_window(4'd0, 4'd0, 8'h04, 24, 1, 0);
`else
    run_window(4'd0, 4'd0, 8'h04, 41, 9, 0);
`endif

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kernel_window_sequencer.md
# kernel_window_sequencer

- Initiator side of the kernel accumulator handshake (`clear`/`start`/`ready`/`clear_flag`/`sum`).
- Accepts a window request, then walks a SIZE×SIZE kernel in raster order:
  - fetches each coefficient and pixel from synchronous-read memories;
  - issues one accumulate per tap;
  - returns the accumulator's 8-bit result on a valid/ready output.
- Sits between the image/kernel buffers and the accumulator in the filter datapath.

## Interface

Parameters:
- `SIZE`, default 3: kernel edge length, legal range 1..7.
- `AW`, default 6: kernel address width; must satisfy 2^AW ≥ SIZE*SIZE.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: window request.
- `req_ready` out 1: high only in IDLE.
- `req_x`, `req_y` in 4 each: window origin; sampled on request accept.
- `kern_addr` out AW: coefficient address, = ty*SIZE+tx.
- `kern_data` in 8: coefficient, valid 1 cycle after address.
- `pix_x`, `pix_y` out 4 each: pixel coordinate, = origin + tap offset, mod 16.
- `pix_data` in 8: pixel, valid 1 cycle after coordinate.
- `acc_clear` out 1: clear pulse to the accumulator.
- `acc_start` out 1: start pulse to the accumulator.
- `acc_kernel_v`, `acc_pixel_v` out 8 each: operands, from holding registers.
- `acc_ready`, `acc_clear_flag` in 1 each: accumulator status.
- `acc_sum` in 8: accumulator result (bits [15:8] of its 16-bit sum).
- `result_valid` out 1, `result_ready` in 1, `result` out 8: output handshake.

## Operation

- States: IDLE, CLEAR, WAIT_CLR, FETCH, LOAD, ISSUE, HOLD, WAIT_SUM, OUT.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `req_x`/`req_y`, set tx=ty=0, go to CLEAR.
- CLEAR:
  - `acc_clear`=1 only while `acc_ready`=1; otherwise wait.
  - After asserting, go to WAIT_CLR.
- WAIT_CLR: wait for `acc_clear_flag`=1, then go to FETCH.
- FETCH: drive `kern_addr`, `pix_x`, `pix_y` for the current tap; go to LOAD.
- LOAD:
  - Capture `kern_data` and `pix_data` into holding registers.
  - Go to ISSUE.
- ISSUE: when `acc_ready`=1, assert `acc_start` for exactly 1 cycle and go to HOLD; otherwise stall.
- HOLD:
  - Holding registers stay unchanged; the accumulator multiplies in this cycle.
  - If more taps remain: advance tx (wrap to 0 and increment ty at SIZE-1), go to FETCH.
  - After the last tap: go to WAIT_SUM.
- WAIT_SUM: when `acc_ready`=1, register `acc_sum` into `result` and go to OUT.
- OUT: `result_valid`=1; on `result_ready` go to IDLE.
- Pulse rules:
  - `acc_clear` and `acc_start` are never high in the same cycle.
  - Each is high for at most 1 cycle per transaction step.
- Operands:
  - `acc_kernel_v` and `acc_pixel_v` are driven only from the holding registers.
  - They are stable from ISSUE through HOLD.
- Coordinates: `pix_x` = `req_x`+tx and `pix_y` = `req_y`+ty, 4-bit, wrapping (14+2 → 0).
- Arithmetic: none of its own. `result` = `acc_sum` verbatim, including the accumulator's 16-bit wrap.

## Timing

- Reset: all outputs 0, including `req_ready`. State is IDLE.
- Reset mid-transaction:
  - Abandon the current transaction immediately; no result is produced.
  - The accumulator is not reset by this block. The next request's CLEAR stalls until `acc_ready`=1.
- Request accepted in cycle T (no accumulator stalls):
  - CLEAR at T+1, WAIT_CLR at T+2, tap k FETCH at T+3+4k.
  - `result_valid` first high at T+5+4·SIZE². For SIZE=3 this is T+41.
- Output backpressure: `result_valid` and `result` hold until `result_ready`; `req_ready` stays 0 meanwhile.
- `req_valid` in the same cycle as the OUT handshake is not accepted that cycle; it is accepted at the next IDLE (no bypass).
- `req_x`/`req_y` changes after acceptance have no effect.

## Configuration

- `KWS_SKIP_ZERO_EN` defined:
  - In LOAD, a tap with `kern_data`==0 skips ISSUE and HOLD.
  - It advances straight to the next FETCH, or to WAIT_SUM if it is the last tap.
  - Each skipped tap saves 2 cycles; a skipped last tap saves 3.
  - An all-zero kernel yields `result`=0x00.
- Undefined: every tap is issued regardless of value; latency is fixed at 4·SIZE²+5.

## Test plan

- SIZE=3, all kernel=0x01, all pixel=0x80, origin (0,0) → `result`=0x04 with `result_valid` at T+41; exactly 9 `acc_start` pulses and 1 `acc_clear`.
- All kernel=0xFF, all pixel=0xFF → sum 585225 mod 65536 = 0xEE09, so `result`=0xEE.
- Origin (14,15) → `pix_x` sequence 14,15,0 per row; `pix_y` rows 15,0,1; `kern_addr` 0..8 in order.
- `result_ready` held low 10 cycles after `result_valid` → `result` stable, `req_ready`=0, a pending `req_valid` is ignored until the handshake completes.
- `rst` asserted during tap 4 ISSUE → next cycle all outputs 0, state IDLE; a following request with all kernel=0x01 and pixel=0x80 returns 0x04.
- Kernel all 0 except center=0x40, center pixel=0x10 → `result`=0x04. Latency T+24 with `KWS_SKIP_ZERO_EN` (1 `acc_start`), T+41 without (9 `acc_start`).
